mul3_serial_tx: RTL and testbench
=================================

Name: mul3_serial_tx

Overview:
- Transmit end of the serial multiple-of-3 link: accepts a parallel word and drives it LSB-first as a one-bit-per-clock stream, plus a frame reset for the downstream detector.
- Simultaneously computes the expected mod-3 residue of the transmitted word, so detector output can be checked in-system.
- Sits upstream of the serial divisibility detector: ser_out drives its I input, frame_res drives its res input.

Parameters:
- WIDTH, 10, number of bits per frame (>= 2).

Ports:
- clk  input  1  system clock, rising-edge.
- res  input  1  synchronous reset, active-high.
- start  input  1  request to transmit data_in; sampled only in IDLE.
- data_in  input  WIDTH  word to transmit, captured on the accepting edge.
- ser_out  output  1  serial data, LSB first.
- frame_res  output  1  one-cycle reset pulse for the downstream detector, preceding bit 0.
- busy  output  1  high from accept until DONE completes.
- done  output  1  one-cycle pulse after the last bit.
- residue  output  2  mod-3 residue of the transmitted word (0..2), valid from done, held until next accept.
- is_mul3  output  1  (residue == 0), qualified like residue.

Behaviour:
- All outputs registered. Reset values: ser_out=0, frame_res=0, busy=0, done=0, residue=0, is_mul3=1, state=IDLE, bit_cnt=0.
- res sampled on rising clk; it overrides everything, including mid-frame.
- Reset mid-frame aborts the frame immediately (no done), then returns to the reset values.
- FSM states: IDLE, SYNC, SHIFT, DONE.
- IDLE:
  - start=1 -> latch data_in into shift_reg, clear acc to 0, busy<=1, go SYNC.
  - start=0 -> stay.
- SYNC (1 cycle): frame_res=1, ser_out=0; go SHIFT with bit_cnt=0.
- SHIFT (WIDTH cycles):
  - ser_out = shift_reg[0]; shift right each cycle.
  - Bit weight: 2^i mod 3 = 1 for even i, 2 for odd i.
  - acc <= (acc + bit*weight) mod 3, computed in 3-bit arithmetic, reduced by a single conditional subtract of 3.
  - Exit after bit_cnt == WIDTH-1 -> DONE.
- DONE (1 cycle):
  - done=1, residue<=acc, is_mul3<=(acc==0), ser_out=0.
  - Then IDLE; busy deasserts on entering IDLE.
- Timing, with start accepted at edge 0:
  - frame_res high during cycle 1.
  - bit i present during cycle 2+i.
  - done high during cycle WIDTH+2.
  - Next start is accepted no earlier than edge WIDTH+3.
- start while busy (SYNC/SHIFT/DONE) is ignored, not queued.
- data_in changes after accept have no effect on the current frame.
- residue and is_mul3 keep the previous frame's value until the next accept, then clear at SYNC (residue=0, is_mul3=1).
- ser_out and frame_res are 0 in every cycle not described above.

Test Plan:
- Reset, then start with data_in=10'b1010101101 (685): ser_out over cycles 2..11 = 1,0,1,1,0,1,0,1,0,1; frame_res high only in cycle 1; done in cycle 12; residue=1, is_mul3=0.
- data_in=10'b0100101010 (298): bits 0,1,0,1,0,1,0,0,1,0; residue=1, is_mul3=0. Repeat for 0, 6 and 1023: residue=0, is_mul3=1 for each.
- Hold start high continuously with data_in=3: exactly one frame per WIDTH+3 cycles; no start accepted during busy; residue=0 every frame.
- Change data_in mid-frame from 3 to 1: serial bits and residue (0) still reflect 3.
- Assert res during SHIFT at bit 4 of 685: next cycle all outputs at reset values, no done pulse; a fresh start on 298 then completes correctly with residue=1.
- Loopback: connect ser_out/frame_res to the detector's I/res and send 50 random words; detector output after the last bit matches is_mul3 every frame.

Source files
------------

// File: rtl/mul3_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : mul3_serial_tx
// Brief    : Serialises a WIDTH-bit word LSB-first with a leading frame-reset
//            pulse for the downstream divisibility detector, and computes the
//            mod-3 residue of the word while it is being shifted out.
// Revision : 1.0 - initial release
// ============================================================================
module mul3_serial_tx #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             ser_out,
    output logic             frame_res,
    output logic             busy,
    output logic             done,
    output logic [1:0]       residue,
    output logic             is_mul3
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   shift_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [1:0]         acc_q;
    logic [1:0]         acc_d;
    logic               ser_out_q;
    logic               frame_res_q;
    logic               busy_q;
    logic               done_q;
    logic [1:0]         residue_q;
    logic               is_mul3_q;

    logic [2:0]         w_weight;
    logic [2:0]         w_sum;

    // Residue update for the bit being launched onto ser_out at this edge.
    // SYNC launches bit 0 (weight 1); in SHIFT the launched bit is
    // bit_cnt+1, which is odd (weight 2) whenever bit_cnt is even.
    always_comb begin
        w_weight = ((state_q == ST_SHIFT) && !bit_cnt_q[0]) ? 3'd2 : 3'd1;
        w_sum    = {1'b0, acc_q} + (shift_q[0] ? w_weight : 3'd0);
        acc_d    = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];
    end

    // Frame sequencer with all outputs registered.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            acc_q       <= 2'd0;
            ser_out_q   <= 1'b0;
            frame_res_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            residue_q   <= 2'd0;
            is_mul3_q   <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ser_out_q   <= 1'b0;
                    frame_res_q <= 1'b0;
                    done_q      <= 1'b0;
                    if (start) begin
                        shift_q     <= data_in;
                        acc_q       <= 2'd0;
                        busy_q      <= 1'b1;
                        frame_res_q <= 1'b1;
                        residue_q   <= 2'd0;
                        is_mul3_q   <= 1'b1;
                        state_q     <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    // Launch bit 0 so it is on the wire in the first SHIFT cycle.
                    frame_res_q <= 1'b0;
                    ser_out_q   <= shift_q[0];
                    shift_q     <= shift_q >> 1;
                    acc_q       <= acc_d;
                    bit_cnt_q   <= '0;
                    state_q     <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    // bit_cnt names the bit currently on ser_out.
                    if (bit_cnt_q == C_LAST_BIT) begin
                        ser_out_q <= 1'b0;
                        done_q    <= 1'b1;
                        residue_q <= acc_q;
                        is_mul3_q <= (acc_q == 2'd0);
                        state_q   <= ST_DONE;
                    end else begin
                        ser_out_q <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        acc_q     <= acc_d;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q    <= 1'b0;
                    busy_q    <= 1'b0;
                    bit_cnt_q <= '0;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ser_out   = ser_out_q;
    assign frame_res = frame_res_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign residue   = residue_q;
    assign is_mul3   = is_mul3_q;

endmodule
`default_nettype wire

// File: tb/tb_mul3_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul3_serial_tx
// Brief    : Directed and random frames for mul3_serial_tx with a residue
//            scoreboard and a serial-side receiver model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul3_serial_tx;

    localparam int WIDTH = 10;

    logic             clk;
    logic             res;
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             ser_out;
    logic             frame_res;
    logic             busy;
    logic             done;
    logic [1:0]       residue;
    logic             is_mul3;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [WIDTH-1:0] word;
        logic [1:0]       res3;
    } exp_t;

    exp_t sb_q[$];

    mul3_serial_tx #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .res       (res),
        .start     (start),
        .data_in   (data_in),
        .ser_out   (ser_out),
        .frame_res (frame_res),
        .busy      (busy),
        .done      (done),
        .residue   (residue),
        .is_mul3   (is_mul3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".ser_out"},   32'(ser_out),   32'd0);
        check({tag, ".frame_res"}, 32'(frame_res), 32'd0);
        check({tag, ".busy"},      32'(busy),      32'd0);
        check({tag, ".done"},      32'(done),      32'd0);
        check({tag, ".residue"},   32'(residue),   32'd0);
        check({tag, ".is_mul3"},   32'(is_mul3),   32'd1);
    endtask

    // Entered in a cycle where the DUT is idle; leaves in the first idle
    // cycle after DONE. keep_start leaves start high for back-to-back frames;
    // change_at >= 0 rewrites data_in to alt_data while bit change_at is out.
    task automatic send_frame(input logic [WIDTH-1:0] d, input bit keep_start,
                              input int change_at, input logic [WIDTH-1:0] alt_data);
        exp_t             e;
        exp_t             got;
        logic [WIDTH-1:0] rx_word;
        bit               rx_mul3;
        e.word  = d;
        e.res3  = 2'(int'(d) % 3);
        data_in = d;
        start   = 1'b1;
        sb_q.push_back(e);
        tick();
        // Cycle 1: frame reset pulse, residue cleared.
        check("sync.frame_res", 32'(frame_res), 32'd1);
        check("sync.ser_out",   32'(ser_out),   32'd0);
        check("sync.busy",      32'(busy),      32'd1);
        check("sync.residue",   32'(residue),   32'd0);
        check("sync.is_mul3",   32'(is_mul3),   32'd1);
        if (!keep_start) start = 1'b0;
        rx_word = '0;
        for (int i = 0; i < WIDTH; i++) begin
            tick();
            if (i == change_at) data_in = alt_data;
            check("shift.ser_out",   32'(ser_out),   32'(d[i]));
            check("shift.frame_res", 32'(frame_res), 32'd0);
            check("shift.done",      32'(done),      32'd0);
            check("shift.busy",      32'(busy),      32'd1);
            rx_word[i] = ser_out;
        end
        tick();
        // Cycle WIDTH+2: done pulse with the result.
        check("done.done",    32'(done),    32'd1);
        check("done.ser_out", 32'(ser_out), 32'd0);
        if (sb_q.size() == 0) begin
            check("done.scoreboard_empty", 32'(sb_q.size()), 32'd1);
        end else begin
            got = sb_q.pop_front();
            check("done.residue", 32'(residue), 32'(got.res3));
            check("done.is_mul3", 32'(is_mul3), 32'(got.res3 == 2'd0));
            rx_mul3 = ((int'(rx_word) % 3) == 0);
            check("loopback.word",    32'(rx_word), 32'(got.word));
            check("loopback.is_mul3", 32'(is_mul3), 32'(rx_mul3));
        end
        tick();
        // Cycle WIDTH+3: idle again, result held.
        check("idle.busy",    32'(busy),    32'd0);
        check("idle.done",    32'(done),    32'd0);
        check("idle.residue", 32'(residue), 32'(e.res3));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        res      = 1'b1;
        start    = 1'b0;
        data_in  = '0;
        tick();
        tick();
        check_reset_values("reset");
        res = 1'b0;
        tick();
        check_reset_values("idle_no_start");

        // Directed words.
        send_frame(10'd685,  1'b0, -1, '0);
        send_frame(10'd298,  1'b0, -1, '0);
        send_frame(10'd0,    1'b0, -1, '0);
        send_frame(10'd6,    1'b0, -1, '0);
        send_frame(10'd1023, 1'b0, -1, '0);

        // start held high: one frame per WIDTH+3 cycles.
        send_frame(10'd3, 1'b1, -1, '0);
        send_frame(10'd3, 1'b1, -1, '0);
        send_frame(10'd3, 1'b0, -1, '0);
        tick();
        check("hold.no_extra_accept", 32'(busy), 32'd0);

        // data_in rewritten mid-frame.
        send_frame(10'd3, 1'b0, 2, 10'd1);

        // Reset while bit 4 of 685 is on the wire.
        data_in = 10'd685;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("abort.bit4", 32'(ser_out), 32'(data_in[4]));
        res = 1'b1;
        tick();
        check_reset_values("abort");
        res = 1'b0;
        for (int i = 0; i < WIDTH + 2; i++) begin
            tick();
            check("abort.no_done", 32'(done), 32'd0);
        end
        send_frame(10'd298, 1'b0, -1, '0);

        // Random words through the receiver model.
        for (int k = 0; k < 50; k++) begin
            send_frame(WIDTH'($urandom_range(0, (1 << WIDTH) - 1)), 1'b0, -1, '0);
        end

        check("scoreboard.drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
